// File: rtl/seq_mult4_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
//   DefaultWidth : default operand width (product is 2*WIDTH bits)
//   state_e      : controller states (Idle=0, Busy=1, Done=2)
// Optional feature macro: SEQ_MULT_OVF_EN (adds the ovf output, see seq_mult4).
package seq_mult4_pkg;

    localparam int unsigned DefaultWidth = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/seq_mult4_if.sv
// Operand/product handshake bundle for seq_mult4.
//   in_valid/in_ready/a/b        : operand pair, accepted on in_valid && in_ready
//   out_valid/out_ready/product  : product, consumed on out_valid && out_ready
//   ovf                          : only with SEQ_MULT_OVF_EN, upper product half non-zero
// Modports: master = operand producer / product consumer, slave = the multiplier.
interface seq_mult4_if
    import seq_mult4_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) ();

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] product;
`ifdef SEQ_MULT_OVF_EN
    logic               ovf;
`endif

    modport master (
        output in_valid, a, b, out_ready,
`ifdef SEQ_MULT_OVF_EN
        input  ovf,
`endif
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, a, b, out_ready,
`ifdef SEQ_MULT_OVF_EN
        output ovf,
`endif
        output in_ready, out_valid, product
    );

endinterface

// File: rtl/seq_mult4_ripple_add_n.sv
// WIDTH-bit ripple-carry adder built from one-bit full-adder cells.
//   a_i, b_i : addends
//   cin_i    : carry in
//   sum_o    : WIDTH-bit sum
//   cout_o   : carry out of the MSB cell
module seq_mult4_ripple_add_n
    import seq_mult4_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin_i;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
        assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = carry[WIDTH];

endmodule

// File: rtl/seq_mult4.sv
// Sequential shift-and-add unsigned multiplier: one operand pair per handshake,
// WIDTH add/shift iterations, 2*WIDTH-bit exact product on a valid/ready output.
//   clk_i : rising-edge clock
//   rst_i : synchronous active-high reset (aborts any operation in flight)
//   bus   : seq_mult4_if.slave (in_valid/in_ready/a/b, out_valid/out_ready/product[/ovf])
// Optional feature macro: SEQ_MULT_OVF_EN -- drives bus.ovf = |product[2W-1:W],
// registered with the product and cleared by reset.
module seq_mult4
    import seq_mult4_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic       clk_i,
    input  logic       rst_i,
    seq_mult4_if.slave bus
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    state_e             state_q;
    logic [CntW-1:0]    count_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] product_q;
    logic               in_ready_q;
    logic               out_valid_q;
`ifdef SEQ_MULT_OVF_EN
    logic               ovf_q;
`endif

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               cout;
    logic [2*WIDTH-1:0] acc_next;

    // Multiplier bit currently at acc[0] selects whether mcand is added to the upper half.
    assign addend = acc_q[0] ? mcand_q : '0;

    seq_mult4_ripple_add_n #(
        .WIDTH (WIDTH)
    ) u_add (
        .a_i    (acc_q[2*WIDTH-1:WIDTH]),
        .b_i    (addend),
        .cin_i  (1'b0),
        .sum_o  (sum),
        .cout_o (cout)
    );

    // Carry enters at the MSB as the accumulator shifts right, so no bit is lost.
    assign acc_next = {cout, sum, acc_q[WIDTH-1:1]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            count_q     <= '0;
            mcand_q     <= '0;
            acc_q       <= '0;
            product_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef SEQ_MULT_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid && in_ready_q) begin
                        mcand_q    <= bus.a;
                        acc_q      <= {{WIDTH{1'b0}}, bus.b};
                        count_q    <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= StBusy;
                    end
                end
                StBusy: begin
                    acc_q   <= acc_next;
                    count_q <= count_q + CntW'(1);
                    if (count_q == CntW'(WIDTH - 1)) begin
                        count_q     <= '0;
                        product_q   <= acc_next;
                        out_valid_q <= 1'b1;
`ifdef SEQ_MULT_OVF_EN
                        ovf_q       <= |acc_next[2*WIDTH-1:WIDTH];
`endif
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    // in_ready rises only after this edge, so a new pair waits one cycle.
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.product   = product_q;
`ifdef SEQ_MULT_OVF_EN
    assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_seq_mult4.sv
// Self-checking bench for seq_mult4: directed vector table, handshake corner
// sequences (backpressure, reset abort, accept spacing) and a randomized run
// against a product scoreboard.
module tb_seq_mult4;

    localparam int unsigned W        = 4;
    localparam int          LatBound = 40;
    localparam int          NumRand  = 200;

    logic clk;
    logic rst;

    seq_mult4_if #(.WIDTH(W)) bus ();

    seq_mult4 #(
        .WIDTH (W)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Present operands and complete the accept edge; returns #1 after that edge.
    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Count edges until out_valid appears; flags any in_ready seen while busy.
    task automatic wait_out(output int lat, output logic saw_ready);
        lat       = 0;
        saw_ready = 1'b0;
        while (!bus.out_valid && lat < LatBound) begin
            if (bus.in_ready) saw_ready = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] prod;
        logic           ovf;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int             lat;
        logic           saw_ready;
        logic [2*W-1:0] held;

        vecs[0] = '{a: 4'h3, b: 4'h5, prod: 8'h0F, ovf: 1'b0};
        vecs[1] = '{a: 4'hF, b: 4'hF, prod: 8'hE1, ovf: 1'b1};
        vecs[2] = '{a: 4'h0, b: 4'h9, prod: 8'h00, ovf: 1'b0};
        vecs[3] = '{a: 4'h9, b: 4'h0, prod: 8'h00, ovf: 1'b0};
        vecs[4] = '{a: 4'h8, b: 4'h2, prod: 8'h10, ovf: 1'b1};
        vecs[5] = '{a: 4'h1, b: 4'hF, prod: 8'h0F, ovf: 1'b0};
        vecs[6] = '{a: 4'hC, b: 4'hA, prod: 8'h78, ovf: 1'b1};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset product", 32'(bus.product), 32'd0);
`ifdef SEQ_MULT_OVF_EN
        check("reset ovf", 32'(bus.ovf), 32'd0);
`endif
        rst = 1'b0;

        // Directed table. out_valid is visible after the WIDTH-th edge following
        // the accept edge (the 5th edge counting the accept edge itself).
        bus.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            check("table in_ready idle", 32'(bus.in_ready), 32'd1);
            accept(vecs[i].a, vecs[i].b);
            wait_out(lat, saw_ready);
            check("table latency", 32'(lat), 32'(W));
            check("table in_ready busy", 32'(saw_ready), 32'd0);
            check("table product", 32'(bus.product), 32'(vecs[i].prod));
`ifdef SEQ_MULT_OVF_EN
            check("table ovf", 32'(bus.ovf), 32'(vecs[i].ovf));
`endif
            @(posedge clk); #1;
            check("table consumed", 32'(bus.out_valid), 32'd0);
        end

        // Accept spacing with out_ready high: consume edge, then accept one edge later.
        accept(4'h3, 4'h5);
        wait_out(lat, saw_ready);
        bus.a        = 4'h1;
        bus.b        = 4'h1;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        check("spacing consume out_valid", 32'(bus.out_valid), 32'd0);
        check("spacing not accepted yet", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("spacing accepted", 32'(bus.in_ready), 32'd0);
        wait_out(lat, saw_ready);
        check("spacing latency", 32'(lat), 32'(W));
        check("spacing product", 32'(bus.product), 32'h01);
        @(posedge clk); #1;

        // Backpressure: product held, operands ignored while DONE.
        bus.out_ready = 1'b0;
        accept(4'h6, 4'h7);
        wait_out(lat, saw_ready);
        held         = bus.product;
        check("bp product", 32'(held), 32'h2A);
        bus.a        = 4'h2;
        bus.b        = 4'h3;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("bp out_valid held", 32'(bus.out_valid), 32'd1);
            check("bp product held", 32'(bus.product), 32'(held));
            check("bp in_ready low", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp consumed", 32'(bus.out_valid), 32'd0);
        check("bp idle ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("bp next accepted", 32'(bus.in_ready), 32'd0);
        wait_out(lat, saw_ready);
        check("bp next latency", 32'(lat), 32'(W));
        check("bp next product", 32'(bus.product), 32'h06);
        @(posedge clk); #1;

        // Reset abort in the second busy cycle.
        accept(4'hA, 4'h7);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort in_ready", 32'(bus.in_ready), 32'd1);
        check("abort out_valid", 32'(bus.out_valid), 32'd0);
`ifdef SEQ_MULT_OVF_EN
        check("abort ovf", 32'(bus.ovf), 32'd0);
`endif
        accept(4'h2, 4'h3);
        wait_out(lat, saw_ready);
        check("abort next latency", 32'(lat), 32'(W));
        check("abort next product", 32'(bus.product), 32'h06);
        @(posedge clk); #1;

        // Randomized traffic against a scoreboard of exact products.
        begin
            logic [2*W-1:0] q[$];
            logic [2*W-1:0] exp_p;
            int             acc_n = 0;
            int             got_n = 0;
            int             cyc   = 0;
            while ((acc_n < NumRand || got_n < acc_n) && cyc < 20000) begin
                bus.in_valid  = (acc_n < NumRand) && ($urandom_range(0, 3) != 0);
                bus.a         = W'($urandom);
                bus.b         = W'($urandom);
                bus.out_ready = ($urandom_range(0, 2) != 0);
                if (bus.in_valid && bus.in_ready) begin
                    q.push_back({{W{1'b0}}, bus.a} * {{W{1'b0}}, bus.b});
                    acc_n++;
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (q.size() == 0) begin
                        check("rand unexpected product", 32'(bus.product), 32'hFFFF_FFFF);
                    end else begin
                        exp_p = q.pop_front();
                        check("rand product", 32'(bus.product), 32'(exp_p));
`ifdef SEQ_MULT_OVF_EN
                        check("rand ovf", 32'(bus.ovf), 32'(exp_p[2*W-1:W] != '0));
`endif
                    end
                    got_n++;
                end
                @(posedge clk); #1;
                cyc++;
            end
            bus.in_valid = 1'b0;
            check("rand accepted", 32'(acc_n), 32'(NumRand));
            check("rand delivered", 32'(got_n), 32'(NumRand));
            check("rand queue empty", 32'(q.size()), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
